// File: rtl/string_accel_pkg.sv
// Shared register map, CONTROL/STATUS bit positions, FSM and verdict types for the string compare accelerator.
// Pure declarations: no latency or backpressure of its own.
package string_accel_pkg;

  localparam logic [2:0] ADDR_FIFO_A = 3'd0;
  localparam logic [2:0] ADDR_FIFO_B = 3'd1;
  localparam logic [2:0] ADDR_CTRL   = 3'd2;
  localparam logic [2:0] ADDR_STATUS = 3'd3;
  localparam logic [2:0] ADDR_RESULT = 3'd4;

  localparam int CTRL_GO       = 0;
  localparam int CTRL_CLR_A    = 1;
  localparam int CTRL_CLR_B    = 2;
  localparam int CTRL_IRQ_EN   = 3;
  localparam int CTRL_CLR_DONE = 4;

  localparam int STAT_CNT_A_LSB = 0;
  localparam int STAT_CNT_B_LSB = 8;
  localparam int STAT_EMPTY_A   = 16;
  localparam int STAT_FULL_A    = 17;
  localparam int STAT_EMPTY_B   = 18;
  localparam int STAT_FULL_B    = 19;
  localparam int STAT_BUSY      = 20;
  localparam int STAT_DONE      = 21;
  localparam int STAT_OVF       = 22;
  localparam int STAT_UDF       = 23;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    VERD_EQ     = 2'b00,
    VERD_LT     = 2'b01,
    VERD_GT     = 2'b10,
    VERD_RUNOUT = 2'b11
  } verdict_e;

  typedef struct packed {
    verdict_e    verdict;
    logic [15:0] index;
  } result_t;

  function automatic verdict_e cmp_verdict(input logic [7:0] a, input logic [7:0] b);
    if (a < b) return VERD_LT;
    if (a > b) return VERD_GT;
    return VERD_EQ;
  endfunction

endpackage

// File: rtl/string_fifo.sv
// Show-ahead FIFO: head word is visible combinationally, push/pop take effect on the next edge.
// Pushes when full and pops when empty are dropped; clear takes priority over both.
module string_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clr_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_dat_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_dat_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o,
  output logic                     full_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign empty_o    = (cnt_q == '0);
  assign full_o     = (cnt_q == (AW+1)'(DEPTH));
  assign count_o    = cnt_q;
  assign head_dat_o = mem_q[rd_ptr_q];

  assign push_ok = push_i && !full_o && !clr_i;
  assign pop_ok  = pop_i && !empty_o && !clr_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      // Pointers are exactly log2(DEPTH) bits, so the increment wraps on its own.
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      cnt_d = cnt_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/string_fifo_accel.sv
// Avalon-MM string compare engine: two word FIFOs compared byte-wise, one word pair per cycle in RUN.
// readdata is registered (one-cycle read latency); FIFO traffic from the bus is ignored while busy.
module string_fifo_accel
  import string_accel_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        chipselect,
  input  logic        write,
  input  logic        read,
  input  logic [2:0]  address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq
);

  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int BYTES = WIDTH / 8;

  logic [WIDTH-1:0] a_head, b_head;
  logic [CW-1:0]    a_cnt, b_cnt;
  logic             a_empty, a_full, b_empty, b_full;

  state_e      state_q, state_d;
  logic [31:0] readdata_q, readdata_d;
  logic        irq_en_q, irq_en_d;
  logic        done_q, done_d;
  logic        ovf_q, ovf_d;
  logic        udf_q, udf_d;
  result_t     result_q, result_d;
  logic [15:0] idx_q, idx_d;

  logic wr_vld, rd_vld, ctrl_wr;
  logic go_req, clr_done, clr_a, clr_b;
  logic push_a, push_b, av_pop_a, av_pop_b;
  logic busy, run_pop, run_end;
  result_t fin_result;

  logic        cmp_hit;
  logic [15:0] cmp_k;
  verdict_e    cmp_verd;
  logic [7:0]  a_byte, b_byte;
  logic [31:0] status;

  assign wr_vld  = chipselect && write;
  assign rd_vld  = chipselect && read;
  assign ctrl_wr = wr_vld && (address == ADDR_CTRL);

  assign go_req   = ctrl_wr && writedata[CTRL_GO] && (state_q == ST_IDLE);
  assign clr_done = ctrl_wr && writedata[CTRL_CLR_DONE];
  assign clr_a    = ctrl_wr && writedata[CTRL_CLR_A] && !busy;
  assign clr_b    = ctrl_wr && writedata[CTRL_CLR_B] && !busy;

  assign push_a   = wr_vld && (address == ADDR_FIFO_A) && !busy;
  assign push_b   = wr_vld && (address == ADDR_FIFO_B) && !busy;
  assign av_pop_a = rd_vld && (address == ADDR_FIFO_A) && !busy;
  assign av_pop_b = rd_vld && (address == ADDR_FIFO_B) && !busy;

  string_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_fifo_a (
    .clk        (clk),
    .reset_n    (reset_n),
    .clr_i      (clr_a),
    .push_i     (push_a),
    .push_dat_i (WIDTH'(writedata)),
    .pop_i      (av_pop_a || run_pop),
    .head_dat_o (a_head),
    .count_o    (a_cnt),
    .empty_o    (a_empty),
    .full_o     (a_full)
  );

  string_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_fifo_b (
    .clk        (clk),
    .reset_n    (reset_n),
    .clr_i      (clr_b),
    .push_i     (push_b),
    .push_dat_i (WIDTH'(writedata)),
    .pop_i      (av_pop_b || run_pop),
    .head_dat_o (b_head),
    .count_o    (b_cnt),
    .empty_o    (b_empty),
    .full_o     (b_full)
  );

  // First byte position (MSB first) that either differs or is a shared terminator.
  always_comb begin
    cmp_hit  = 1'b0;
    cmp_k    = '0;
    cmp_verd = VERD_EQ;
    a_byte   = '0;
    b_byte   = '0;
    for (int k = 0; k < BYTES; k++) begin
      a_byte = a_head[WIDTH-1-8*k -: 8];
      b_byte = b_head[WIDTH-1-8*k -: 8];
      if (!cmp_hit && ((a_byte != b_byte) || (a_byte == 8'h00))) begin
        cmp_hit  = 1'b1;
        cmp_k    = 16'(k);
        cmp_verd = cmp_verdict(a_byte, b_byte);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (go_req) state_d = ST_RUN;
      ST_RUN:  if (a_empty || b_empty || cmp_hit) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q != ST_IDLE);
    run_pop = (state_q == ST_RUN) && !a_empty && !b_empty;
    run_end = (state_q == ST_RUN) && (a_empty || b_empty || cmp_hit);
    if (a_empty || b_empty) fin_result = '{verdict: VERD_RUNOUT, index: idx_q};
    else                    fin_result = '{verdict: cmp_verd, index: idx_q + cmp_k};
  end

  always_comb begin
    status = '0;
    status[STAT_CNT_A_LSB +: 8] = 8'(a_cnt);
    status[STAT_CNT_B_LSB +: 8] = 8'(b_cnt);
    status[STAT_EMPTY_A] = a_empty;
    status[STAT_FULL_A]  = a_full;
    status[STAT_EMPTY_B] = b_empty;
    status[STAT_FULL_B]  = b_full;
    status[STAT_BUSY]    = busy;
    status[STAT_DONE]    = done_q;
    status[STAT_OVF]     = ovf_q;
    status[STAT_UDF]     = udf_q;
  end

  always_comb begin
    idx_d      = idx_q;
    result_d   = result_q;
    done_d     = done_q;
    irq_en_d   = ctrl_wr ? writedata[CTRL_IRQ_EN] : irq_en_q;
    ovf_d      = (ovf_q && !clr_done) || (push_a && a_full) || (push_b && b_full);
    udf_d      = (udf_q && !clr_done) || (av_pop_a && a_empty) || (av_pop_b && b_empty);
    readdata_d = readdata_q;

    if (go_req) begin
      idx_d    = '0;
      result_d = '0;
      done_d   = 1'b0;
    end else begin
      if (run_pop && !cmp_hit) idx_d = idx_q + 16'(BYTES);
      if (run_end)       begin result_d = fin_result; done_d = 1'b1; end
      else if (clr_done) done_d = 1'b0;
    end

    if (rd_vld) begin
      case (address)
        ADDR_FIFO_A: readdata_d = (av_pop_a && !a_empty) ? 32'(a_head) : 32'd0;
        ADDR_FIFO_B: readdata_d = (av_pop_b && !b_empty) ? 32'(b_head) : 32'd0;
        ADDR_CTRL:   readdata_d = {28'd0, irq_en_q, 3'd0};
        ADDR_STATUS: readdata_d = status;
        ADDR_RESULT: readdata_d = {14'd0, result_q};
        default:     readdata_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      readdata_q <= '0;
      irq_en_q   <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      result_q   <= '0;
      idx_q      <= '0;
    end else begin
      readdata_q <= readdata_d;
      irq_en_q   <= irq_en_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
      result_q   <= result_d;
      idx_q      <= idx_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = done_q && irq_en_q;

endmodule
